// File: rtl/local_network_interface.sv
// local_network_interface: bridges a processing core and its router's local port.
// TX path packs core requests into single-flit packets and drives them into the
// router with val/ret flow control; RX path filters flits by destination and
// buffers their payloads for the core. Both paths use small circular FIFOs.
module local_network_interface #(
    parameter int DATA_WIDTH = 8,
    parameter int N_ADD      = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int PTR_W      = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_ADD-1:0]              X_address,
    input  logic [N_ADD-1:0]              Y_address,
    input  logic                          tx_wr_en,
    input  logic [N_ADD-1:0]              tx_dest_x,
    input  logic [N_ADD-1:0]              tx_dest_y,
    input  logic [DATA_WIDTH-2*N_ADD-1:0] tx_payload,
    output logic                          tx_full,
    output logic [DATA_WIDTH-1:0]         Package_out,
    output logic                          val_out,
    input  logic                          ret_in,
    input  logic [DATA_WIDTH-1:0]         Package_in,
    input  logic                          val_in,
    output logic                          ret_out,
    input  logic                          rx_rd_en,
    output logic [DATA_WIDTH-2*N_ADD-1:0] rx_payload,
    output logic                          rx_empty,
    output logic [2:0]                    err,
    input  logic                          err_clr
);

    localparam int               PL_W    = DATA_WIDTH - 2*N_ADD;
    localparam logic [PTR_W:0]   DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] tx_mem_q [FIFO_DEPTH];
    logic [PL_W-1:0]       rx_mem_q [FIFO_DEPTH];

    logic [PTR_W-1:0] tx_rd_q, tx_rd_d, tx_wr_q, tx_wr_d;
    logic [PTR_W-1:0] rx_rd_q, rx_rd_d, rx_wr_q, rx_wr_d;
    logic [PTR_W:0]   tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic [2:0]       err_q, err_d, err_set;

    logic tx_empty, tx_push, tx_pop;
    logic rx_push, rx_pop, dest_ok;

    // Status flags come straight from registered counts, so ret_out has no
    // combinational path from val_in.
    assign tx_full  = (tx_cnt_q == DEPTH_C);
    assign tx_empty = (tx_cnt_q == '0);
    assign ret_out  = (rx_cnt_q == DEPTH_C);
    assign rx_empty = (rx_cnt_q == '0);

    assign tx_push     = tx_wr_en && !tx_full;
    assign val_out     = !tx_empty && !ret_in;
    assign tx_pop      = val_out;
    assign Package_out = tx_empty ? '0 : tx_mem_q[tx_rd_q];

    assign dest_ok    = (Package_in[N_ADD-1:0] == X_address) &&
                        (Package_in[2*N_ADD-1:N_ADD] == Y_address);
    assign rx_push    = val_in && !ret_out && dest_ok;
    assign rx_pop     = rx_rd_en && !rx_empty;
    assign rx_payload = rx_empty ? '0 : rx_mem_q[rx_rd_q];

    assign err = err_q;

    // Next-state for pointers, counts and sticky error flags.
    always_comb begin
        tx_rd_d  = tx_rd_q;
        tx_wr_d  = tx_wr_q;
        tx_cnt_d = tx_cnt_q;
        rx_rd_d  = rx_rd_q;
        rx_wr_d  = rx_wr_q;
        rx_cnt_d = rx_cnt_q;

        if (tx_push) tx_wr_d = tx_wr_q + 1'b1;
        if (tx_pop)  tx_rd_d = tx_rd_q + 1'b1;
        case ({tx_push, tx_pop})
            2'b10:   tx_cnt_d = tx_cnt_q + 1'b1;
            2'b01:   tx_cnt_d = tx_cnt_q - 1'b1;
            default: tx_cnt_d = tx_cnt_q;
        endcase

        if (rx_push) rx_wr_d = rx_wr_q + 1'b1;
        if (rx_pop)  rx_rd_d = rx_rd_q + 1'b1;
        case ({rx_push, rx_pop})
            2'b10:   rx_cnt_d = rx_cnt_q + 1'b1;
            2'b01:   rx_cnt_d = rx_cnt_q - 1'b1;
            default: rx_cnt_d = rx_cnt_q;
        endcase

        err_set[0] = tx_wr_en && tx_full;
        err_set[1] = val_in && ret_out;
        err_set[2] = val_in && !ret_out && !dest_ok;
        // New events win over a same-cycle clear.
        err_d = err_clr ? err_set : (err_q | err_set);
    end

    // Control state with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_rd_q  <= '0;
            tx_wr_q  <= '0;
            tx_cnt_q <= '0;
            rx_rd_q  <= '0;
            rx_wr_q  <= '0;
            rx_cnt_q <= '0;
            err_q    <= '0;
        end else begin
            tx_rd_q  <= tx_rd_d;
            tx_wr_q  <= tx_wr_d;
            tx_cnt_q <= tx_cnt_d;
            rx_rd_q  <= rx_rd_d;
            rx_wr_q  <= rx_wr_d;
            rx_cnt_q <= rx_cnt_d;
            err_q    <= err_d;
        end
    end

    // FIFO storage; contents are don't-care while a FIFO is empty, so no reset.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem_q[tx_wr_q] <= {tx_payload, tx_dest_y, tx_dest_x};
        if (rx_push) rx_mem_q[rx_wr_q] <= Package_in[DATA_WIDTH-1:2*N_ADD];
    end

endmodule

// File: doc/local_network_interface.md
# local_network_interface

Network interface between a local processing core and a router's local (L) port. The transmit path packs core requests into single-flit packets, buffers them, and drives them into the router's local input using the val/ret handshake. The receive path accepts flits from the router's local output, checks their destination, buffers them for the core, and drives ret back to the router. It sits beside each router in the mesh, one instance per node.

## Interface
- DATA_WIDTH, 8: flit width.
- N_ADD, 2: width of one mesh coordinate.
- FIFO_DEPTH, 4: entries per FIFO. Must be a power of 2 and at least 2.
- PTR_W, 2: log2(FIFO_DEPTH).
- PL_W (derived, not overridable): DATA_WIDTH-2*N_ADD, the payload width.

Ports (single clock; reset is asynchronous and active-low):
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous active-low reset.
- X_address  in  N_ADD  this node's X coordinate.
- Y_address  in  N_ADD  this node's Y coordinate.
- tx_wr_en  in  1  core pushes one packet.
- tx_dest_x  in  N_ADD  destination X.
- tx_dest_y  in  N_ADD  destination Y.
- tx_payload  in  PL_W  payload.
- tx_full  out  1  TX FIFO holds FIFO_DEPTH entries.
- Package_out  out  DATA_WIDTH  flit to the router's local input.
- val_out  out  1  flit on Package_out is valid this cycle.
- ret_in  in  1  router local input buffer is full; do not send.
- Package_in  in  DATA_WIDTH  flit from the router's local output.
- val_in  in  1  flit on Package_in is valid.
- ret_out  out  1  RX FIFO is full.
- rx_rd_en  in  1  core pops one received payload.
- rx_payload  out  PL_W  payload at the RX head.
- rx_empty  out  1  RX FIFO holds no entries.
- err  out  3  sticky flags: [0] tx overflow, [1] rx overflow, [2] misroute.
- err_clr  in  1  synchronous clear of err.

## Operation
- Flit format:
  - [N_ADD-1:0] is destination X.
  - [2*N_ADD-1:N_ADD] is destination Y.
  - [DATA_WIDTH-1:2*N_ADD] is payload.
  - Every packet is exactly one flit.
- **TX FIFO** (circular buffer with rd_ptr, wr_ptr, and a count of width PTR_W+1):
  - Push: when tx_wr_en=1 and tx_full=0, the flit {tx_payload, tx_dest_y, tx_dest_x} is written.
  - tx_wr_en=1 while tx_full=1: the write is dropped and err[0] is set. A pop in the same cycle does not rescue the write; tx_full is evaluated before the edge.
  - Pointers wrap modulo FIFO_DEPTH.
- **TX drive:**
  - Package_out = head flit while the FIFO is non-empty, else 0.
  - val_out = TX non-empty AND ret_in=0. val_out is combinational in ret_in.
  - Every cycle val_out=1 is one transfer: the head pops at the edge.
  - Back-to-back transfers at one flit per cycle are required.
- **RX accept:**
  - When val_in=1 and ret_out=0: if the flit's X/Y fields equal X_address/Y_address, its payload is pushed. Otherwise it is discarded and err[2] is set.
  - val_in=1 while ret_out=1: the flit is discarded and err[1] is set.
- **RX drain:**
  - rx_payload = head payload while rx_empty=0, else 0.
  - rx_rd_en=1 with rx_empty=0 pops at the edge.
  - rx_rd_en=1 on empty is ignored, with no error.
  - A simultaneous push and pop leaves the count unchanged.
- **Status:**
  - ret_out = (rx count == FIFO_DEPTH), decoded from registers only, so there is no combinational path from val_in.
  - tx_full and rx_empty are also decoded from registered counts.
- **err:**
  - Bits are set-dominant over err_clr in the same cycle.
  - err_clr=1 with no new event clears all bits at the edge.

## Timing
- **Reset** (rst=0, asynchronous): both FIFOs are emptied, pointers and counts go to 0, and err=0.
  - Resulting outputs: tx_full=0, val_out=0, Package_out=0, ret_out=0, rx_empty=1, rx_payload=0.
  - Reset mid-transfer loses all buffered flits. No partial state survives.
- **TX latency:** a push at edge N gives val_out=1 in cycle N+1 if ret_in=0. The transfer completes at edge N+1.
- **ret_in** rising in any cycle suppresses val_out in that same cycle. No flit is lost or duplicated.
- **RX latency:** a flit accepted at edge N gives rx_empty=0 and a valid rx_payload in cycle N+1.
- **ret_out:** rises in the cycle after the accept that filled the FIFO, and falls in the cycle after the pop that frees an entry.
- Each FIFO sustains one push and one pop per cycle with no bubbles.

## Test plan
- **Reset values:** with rst=0, check the listed output values. Then push 1 TX packet, dest (2,1), payload 0xA. Required: in the next cycle Package_out=0xA6 and val_out=1. With ret_in=0, val_out=0 in the following cycle.
- **TX backpressure:** fill the TX FIFO with 4 packets while ret_in=1. Required: tx_full=1, val_out=0. A 5th push sets err[0] and the FIFO contents are unchanged. Release ret_in: required 4 consecutive val_out cycles, in push order.
- **RX accept, node (1,1):** 4 back-to-back flits 0x15, 0x25, 0x35, 0x45. Required: ret_out=1 after the 4th. A 5th val_in sets err[1]. Popping returns payloads 1, 2, 3, 4.
- **Misroute:** node (1,1) receives flit 0x16. Required: discarded, rx_empty stays 1, err[2]=1. err_clr then clears err to 0.
- **Simultaneous push/pop:** with the RX FIFO full, assert rx_rd_en and present a new valid flit. Required: the flit is dropped and err[1] is set, because ret_out=1 before the edge; the count becomes 3. The TX FIFO at count 2, with push and transfer in the same cycle, stays at count 2.
- **Reset mid-operation:** rst=0 with 3 flits in each FIFO. Required: reset values immediately, without waiting for a clock edge. No stale flit appears after rst=1.
